// File: rtl/byte_sel_pipe.sv
// byte_sel_pipe: registered N-to-1 channel selector with valid/ready on both
// sides. Two arbitration modes:
//   mode=0 : explicit select, channel 'sel' wins if it is valid and in range
//   mode=1 : round-robin, search starts one past the last granted channel
// The output is a single registered stage that can be refilled in the same
// cycle it drains, so it sustains one item per cycle.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   mode, sel           arbitration mode and explicit channel index
//   in_data[NCH*WIDTH]  channel k at [k*WIDTH +: WIDTH]
//   in_valid/in_ready   per-channel handshake (at most one ready bit high)
//   out_data/out_ch     registered item and the channel that supplied it
//   out_valid/out_ready output handshake

// Per-channel eligibility and search-order rank. In round-robin mode the rank
// is the distance from the slot after rr_ptr, so the eligible lane with the
// lowest rank is the round-robin winner. In explicit mode at most one lane is
// eligible and rank is irrelevant.
module byte_sel_lane #(
  parameter int NCH  = 4,
  parameter int SELW = 2,
  parameter int K    = 0
) (
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [SELW-1:0] rr_ptr,
  input  logic            valid,
  output logic            elig,
  output logic [SELW-1:0] rank
);
  always_comb begin
    int r;
    r = K - int'(rr_ptr) - 1;
    if (r < 0) r = r + NCH;
    // sel values >= NCH match no lane, giving a silent no-grant
    elig = valid && (mode || (sel == SELW'(K)));
    rank = mode ? SELW'(r) : '0;
  end
endmodule

module byte_sel_pipe #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SELW-1:0]           rr_ptr;
  logic [NCH-1:0]            elig;
  logic [NCH-1:0][SELW-1:0]  rank;
  logic [SELW-1:0]           g;
  logic                      grant;
  logic                      load;
  int                        best;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    byte_sel_lane #(.NCH(NCH), .SELW(SELW), .K(k)) u_lane (
      .mode   (mode),
      .sel    (sel),
      .rr_ptr (rr_ptr),
      .valid  (in_valid[k]),
      .elig   (elig[k]),
      .rank   (rank[k])
    );
  end

  // Min-rank reduction over eligible lanes; best==NCH means nobody asked.
  always_comb begin
    best = NCH;
    g    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (elig[k] && (int'(rank[k]) < best)) begin
        best = int'(rank[k]);
        g    = SELW'(k);
      end
    end
    grant = (best < NCH);
  end

  // Output register is free when empty or draining this cycle.
  assign load     = !out_valid || out_ready;
  assign in_ready = (load && grant) ? (NCH'(1) << g) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SELW'(NCH - 1);   // first round-robin grant lands on ch0
    end else if (load) begin
      if (grant) begin
        out_data  <= in_data[g*WIDTH +: WIDTH];
        out_ch    <= g;
        out_valid <= 1'b1;
        rr_ptr    <= g;              // tracked in both modes
      end else begin
        out_valid <= 1'b0;           // data/ch keep stale values
      end
    end
  end

endmodule

// File: tb/tb_byte_sel_pipe.sv
module tb_byte_sel_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: NCH=4
  logic        a_mode;
  logic [1:0]  a_sel;
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_ch;
  logic        a_out_valid, a_out_ready;

  // DUT B: NCH=3, so sel=3 is out of range
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_ch;
  logic        b_out_valid, b_out_ready;

  byte_sel_pipe #(.WIDTH(8), .NCH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
    .out_ready(a_out_ready));

  byte_sel_pipe #(.WIDTH(8), .NCH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
    .out_ready(b_out_ready));

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per DUT: held item, its channel, and last granted channel.
  int mv[2], md[2], mc[2], ml[2];
  int nch[2] = '{4, 3};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Winning channel by the selection rules, or -1 for no grant.
  function automatic int arb(int n, bit md_rr, int s, int valid, int last);
    if (!md_rr) return (s < n && ((valid >> s) & 1) == 1) ? s : -1;
    for (int off = 1; off <= n; off++) begin
      int c;
      c = (last + off) % n;
      if (((valid >> c) & 1) == 1) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mv[d] = 0; md[d] = 0; mc[d] = 0; ml[d] = nch[d] - 1;
    end
  endtask

  // One cycle: inputs already driven (just after negedge). Check in_ready
  // before the edge, advance the model at the edge, check outputs after.
  task automatic step();
    int  gr[2];
    bit  ld[2];
    int  dat[2];
    gr[0] = arb(4, a_mode, int'(a_sel), int'(a_in_valid), ml[0]);
    gr[1] = arb(3, b_mode, int'(b_sel), int'(b_in_valid), ml[1]);
    ld[0] = (mv[0] == 0) || a_out_ready;
    ld[1] = (mv[1] == 0) || b_out_ready;
    dat[0] = (gr[0] >= 0) ? int'((a_in_data >> (8 * gr[0])) & 32'hFF) : 0;
    dat[1] = (gr[1] >= 0) ? int'((b_in_data >> (8 * gr[1])) & 24'hFF) : 0;
    #1;
    check("a_in_ready", 32'(a_in_ready), (ld[0] && gr[0] >= 0) ? (32'd1 << gr[0]) : 32'd0);
    check("b_in_ready", 32'(b_in_ready), (ld[1] && gr[1] >= 0) ? (32'd1 << gr[1]) : 32'd0);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (ld[d]) begin
        if (gr[d] >= 0) begin
          mv[d] = 1; md[d] = dat[d]; mc[d] = gr[d]; ml[d] = gr[d];
        end else mv[d] = 0;
      end
    end
    @(negedge clk);
    check("a_out_valid", 32'(a_out_valid), mv[0]);
    check("a_out_data",  32'(a_out_data),  md[0]);
    check("a_out_ch",    32'(a_out_ch),    mc[0]);
    check("b_out_valid", 32'(b_out_valid), mv[1]);
    check("b_out_data",  32'(b_out_data),  md[1]);
    check("b_out_ch",    32'(b_out_ch),    mc[1]);
  endtask

  initial begin
    rst_n = 1'b0;
    a_mode = 0; a_sel = 0; a_in_data = 0; a_in_valid = 0; a_out_ready = 1;
    b_mode = 0; b_sel = 0; b_in_data = 0; b_in_valid = 0; b_out_ready = 1;
    model_reset();
    #2;
    check("reset_out_valid", 32'(a_out_valid), 0);
    check("reset_out_data",  32'(a_out_data),  0);
    check("reset_out_ch",    32'(a_out_ch),    0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin all valid: 0,1,2,3,0,1,2,3. Meanwhile B: explicit sel=2 then sel=3.
    a_mode = 1; a_in_valid = 4'hF; a_in_data = 32'h44332211;
    b_mode = 0; b_sel = 2; b_in_valid = 3'b111; b_in_data = 24'hCCBBAA;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) b_sel = 3;
      step();
      check("rr_seq_all", 32'(a_out_ch), i % 4);
      if (i == 3) check("b_sel2_data", 32'(b_out_data), 32'hCC);
    end
    check("b_oor_valid", 32'(b_out_valid), 0);
    check("b_oor_ready", 32'(b_in_ready), 0);

    // Round-robin with valid 1010: alternates 1,3. B round-robin over 101.
    a_in_valid = 4'b1010;
    b_mode = 1; b_in_valid = 3'b101;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_seq_1010", 32'(a_out_ch), (i % 2 == 0) ? 1 : 3);
      check("b_rr_seq_101", 32'(b_out_ch), (i % 2 == 0) ? 0 : 2);
    end
    b_in_valid = 0;

    // Explicit select ch2 = A5.
    a_mode = 0; a_sel = 2; a_in_valid = 4'b0100; a_in_data = 32'h00A50000;
    #1 check("expl_in_ready", 32'(a_in_ready), 32'b0100);
    step();
    check("expl_data", 32'(a_out_data), 32'hA5);
    check("expl_ch",   32'(a_out_ch),   2);
    a_in_valid = 4'b1011;                     // ch2 now invalid
    step();
    check("expl_drain_valid", 32'(a_out_valid), 0);

    // Backpressure: hold 3C through 3 stalled cycles.
    a_sel = 1; a_in_valid = 4'b0010; a_in_data = 32'h00003C00;
    step();
    check("bp_load", 32'(a_out_data), 32'h3C);
    a_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_sel = 2'(i); a_in_valid = 4'hF; a_in_data = 32'h01020304 * (i + 2);
      step();
      check("bp_hold_data", 32'(a_out_data), 32'h3C);
      check("bp_in_ready",  32'(a_in_ready), 0);
    end
    a_out_ready = 1; a_sel = 3; a_in_valid = 4'b1000; a_in_data = 32'h77000000;
    step();
    check("bp_refill_valid", 32'(a_out_valid), 1);
    check("bp_refill_data",  32'(a_out_data),  32'h77);

    // Mode switch: explicit ch1, then round-robin picks ch2.
    a_sel = 1; a_in_valid = 4'hF; a_in_data = 32'h44332211;
    step();
    check("ms_expl_ch", 32'(a_out_ch), 1);
    a_mode = 1;
    step();
    check("ms_rr_ch", 32'(a_out_ch), 2);

    // Asynchronous reset while holding an item.
    a_out_ready = 0;
    check("pre_rst_valid", 32'(a_out_valid), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_valid", 32'(a_out_valid), 0);
    check("rst_async_data",  32'(a_out_data),  0);
    check("rst_async_ch",    32'(a_out_ch),    0);
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1;
    step();
    check("post_rst_first", 32'(a_out_ch), 0);
    step();
    check("post_rst_second", 32'(a_out_ch), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/byte_sel_pipe.md
Name: byte_sel_pipe

Overview:
- Parametrised, registered N-to-1 selector with valid/ready handshakes. It generalises the team's combinational byte muxes: channel count and width are parameters, and the output is a registered stage.
- Two selection modes: explicit (software/FSM select) and fair round-robin across valid channels.
- Sits between byte-wide AES datapath sources (state bytes, key bytes, S-box results) and single consumers such as the S-box feed and the output shifter.

Parameters:
- WIDTH, 8, data width per channel in bits.
- NCH, 4, number of input channels; legal range 2..16, not necessarily a power of 2.
- SELW, $clog2(NCH), select/channel-index width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = explicit select via sel; 1 = round-robin.
- sel  input  SELW  channel index used when mode=0.
- in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; at most one bit high per cycle.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_ch hold a valid item.
- out_ready  input  1  consumer accepts the item this cycle.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=NCH-1 so the first round-robin grant goes to channel 0. Held data is discarded when reset asserts mid-operation.
- Load enable: load = !out_valid || out_ready.
- Grant in mode=0:
  - g = sel when sel < NCH and in_valid[sel]; otherwise no grant.
  - sel >= NCH gives no grant and no error.
- Grant in mode=1:
  - Search from rr_ptr+1 upward, modulo NCH; g = first channel with in_valid set.
  - No grant when in_valid == 0.
- in_ready[g] = load && grant exists. All other in_ready bits are 0.
  - in_ready is combinational from in_valid, mode, sel and state.
  - No combinational path from out_ready to out_data.
- On transfer (in_valid[g] && in_ready[g]), at the next edge: out_data <= channel g data; out_ch <= g; out_valid <= 1; rr_ptr <= g. rr_ptr updates in both modes.
- When load=1 and there is no grant: out_valid <= 0. out_data and out_ch hold their stale values.
- When load=0 (out_valid && !out_ready): out_data, out_ch, out_valid and rr_ptr are all held. Output must be stable while stalled.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Throughput is 1 item per cycle, including simultaneous drain and refill: out_valid stays 1 and data is replaced.
- Changes to mode or sel affect only the next arbitration, never the held item.
- Round-robin fairness: a continuously valid channel is granted within NCH transfers.
- Data integrity: no item is lost or duplicated. Each accepted input produces exactly one output handshake.

Test Plan:
- Reset: drive rst_n low mid-stream while out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately (no clock edge needed). After release with mode=1 and all valid, first grant is ch0.
- Explicit mode: NCH=4, mode=0, sel=2, ch2=0xA5 valid, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=0xA5, out_ch=2, out_valid=1. With sel=2 and ch2 invalid -> in_ready=0 and out_valid drops to 0 after the drain.
- Round-robin: mode=1, all four valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. With in_valid=4'b1010 -> out_ch alternates 1,3.
- Backpressure: out_valid=1 holding 0x3C, out_ready=0 for 3 cycles while inputs change -> out_data stays 0x3C, in_ready=0. On the cycle out_ready=1, the next item is loaded back-to-back with no bubble.
- Out-of-range select: NCH=3 (SELW=2), mode=0, sel=3, all valid -> no in_ready asserted, out_valid=0.
- Mode switch: after ch1 is granted in mode=0, switch to mode=1 with all valid -> next grant is ch2, confirming rr_ptr tracks the last grant in both modes.
